// File: rtl/text_console_controller.sv
// Byte-stream to screen-RAM sequencer: printable/CR/LF/BS handling, wrap, scroll-up and clear.
// Printable bytes take 2 cycles. Scroll takes 2 cycles per moved cell plus 1 per fill cell. charReady is low whenever the sequencer is not idle.
module text_console_controller #(
  parameter int         COLUMNS   = 80,
  parameter int         ROWS      = 25,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        charValid,
  input  logic [7:0]  charData,
  output logic        charReady,
  input  logic [7:0]  attribute,
  input  logic        clearRequest,
  output logic        busy,
  output logic [6:0]  cursorColumn,
  output logic [4:0]  cursorRow,
  output logic        ramEnable,
  output logic        ramWriteEnable,
  output logic [10:0] ramAddress,
  output logic [15:0] ramDataIn,
  input  logic [15:0] ramDataOut
);

  localparam logic [10:0] COLS_A      = 11'(COLUMNS);
  localparam logic [10:0] SCROLL_LAST = 11'((ROWS - 1) * COLUMNS - 1);
  localparam logic [10:0] CELL_LAST   = 11'(COLUMNS * ROWS - 1);
  localparam logic [6:0]  COL_LAST    = 7'(COLUMNS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SCROLL_READ, S_SCROLL_WRITE, S_FILL, S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] idx_q, idx_d;
  logic [7:0]  char_q, char_d;
  logic        clear_pend_q, clear_pend_d;
  logic        clear_pending;
  logic        do_lf;

  // A request arriving this cycle already blocks the byte interface.
  assign clear_pending = clear_pend_q | clearRequest;
  assign clear_pend_d  = (state_q != S_IDLE) && clear_pending;
  assign charReady     = (state_q == S_IDLE) && !clear_pending && !reset;
  assign busy          = (state_q != S_IDLE) || clear_pending;
  assign cursorColumn  = col_q;
  assign cursorRow     = row_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      char_q       <= '0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      char_q       <= char_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    char_d  = char_q;
    do_lf   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_pending) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (charValid) begin
          case (charData)
            8'h0D: col_d = '0;
            8'h0A: do_lf = 1'b1;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            default: begin
              state_d = S_WRITE;
              char_d  = charData;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          do_lf = 1'b1;
        end else begin
          col_d   = col_q + 7'd1;
          state_d = S_IDLE;
        end
      end
      S_SCROLL_READ: state_d = S_SCROLL_WRITE;
      S_SCROLL_WRITE: begin
        idx_d   = idx_q + 11'd1;
        state_d = (idx_q == SCROLL_LAST) ? S_FILL : S_SCROLL_READ;
      end
      S_FILL: begin
        if (idx_q == CELL_LAST) state_d = S_IDLE;
        else                    idx_d   = idx_q + 11'd1;
      end
      S_CLEAR: begin
        if (idx_q == CELL_LAST) begin
          state_d = S_IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line feed on the bottom row scrolls; a single-row screen only needs the fill.
    if (do_lf) begin
      if (row_q != ROW_LAST) begin
        row_d   = row_q + 5'd1;
        state_d = S_IDLE;
      end else begin
        idx_d   = '0;
        state_d = (ROWS > 1) ? S_SCROLL_READ : S_FILL;
      end
    end
  end

  always_comb begin
    ramEnable      = 1'b0;
    ramWriteEnable = 1'b0;
    ramAddress     = '0;
    ramDataIn      = '0;
    unique case (state_q)
      S_WRITE: begin
        ramEnable      = 1'b1;
        ramWriteEnable = 1'b1;
        ramAddress     = {6'd0, row_q} * COLS_A + {4'd0, col_q};
        ramDataIn      = {attribute, char_q};
      end
      S_SCROLL_READ: begin
        ramEnable  = 1'b1;
        ramAddress = idx_q + COLS_A;
      end
      S_SCROLL_WRITE: begin
        ramEnable      = 1'b1;
        ramWriteEnable = 1'b1;
        ramAddress     = idx_q;
        ramDataIn      = ramDataOut;
      end
      S_FILL, S_CLEAR: begin
        ramEnable      = 1'b1;
        ramWriteEnable = 1'b1;
        ramAddress     = idx_q;
        ramDataIn      = {attribute, FILL_CHAR};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_console_controller.sv
// Bench for text_console_controller: screen-RAM model on port B plus a queue of expected per-cycle outputs.
module tb_text_console_controller;
  localparam int C = 80;
  localparam int R = 25;
  localparam int N = C * R;

  logic        clock = 1'b0, reset = 1'b1;
  logic        charValid = 1'b0, clearRequest = 1'b0;
  logic [7:0]  charData = 8'h00, attribute = 8'h00;
  logic        charReady, busy, ramEnable, ramWriteEnable;
  logic [6:0]  cursorColumn;
  logic [4:0]  cursorRow;
  logic [10:0] ramAddress;
  logic [15:0] ramDataIn;
  logic [15:0] ramDataOut = 16'h0000;

  text_console_controller #(.COLUMNS(C), .ROWS(R), .FILL_CHAR(8'h20)) dut (
    .clock(clock), .reset(reset), .charValid(charValid), .charData(charData),
    .charReady(charReady), .attribute(attribute), .clearRequest(clearRequest),
    .busy(busy), .cursorColumn(cursorColumn), .cursorRow(cursorRow),
    .ramEnable(ramEnable), .ramWriteEnable(ramWriteEnable), .ramAddress(ramAddress),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];
  always @(posedge clock) begin
    if (ramEnable) begin
      if (ramWriteEnable) mem[ramAddress] <= ramDataIn;
      ramDataOut <= mem[ramAddress];
    end
  end

  typedef struct {
    logic        en, we;
    logic [10:0] addr;
    logic [15:0] wd;
    logic        chk_wd;
    logic [6:0]  col;
    logic [4:0]  row;
    logic        bsy, rdy;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic [15:0] scr [0:N-1];
  int          m_col = 0, m_row = 0;
  bit          chk_en = 0, rst_eff = 0, rnd_attr = 0;
  int          vectors = 0, miscompares = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(bit en, bit we, logic [10:0] addr, logic [15:0] wd, bit chk_wd, bit bsy, bit rdy);
    exp_t e;
    e.en = en; e.we = we; e.addr = addr; e.wd = wd; e.chk_wd = chk_wd;
    e.col = 7'(m_col); e.row = 5'(m_row); e.bsy = bsy; e.rdy = rdy;
    q.push_back(e);
  endtask

  // Scroll copies rows 1..R-1 up one row, then blanks the bottom row.
  task automatic gen_scroll();
    logic [15:0] snap [0:N-1];
    for (int k = 0; k < N; k++) snap[k] = scr[k];
    foreach (q[j]) if (q[j].en && q[j].we) snap[q[j].addr] = q[j].wd;
    for (int i = 0; i < (R - 1) * C; i++) begin
      push(1, 0, 11'(i + C), 16'h0, 0, 1, 0);
      push(1, 1, 11'(i), snap[i + C], 1, 1, 0);
      snap[i] = snap[i + C];
    end
    for (int i = (R - 1) * C; i < N; i++) push(1, 1, 11'(i), {attribute, 8'h20}, 1, 1, 0);
  endtask

  task automatic line_feed();
    if (m_row < R - 1) m_row++;
    else gen_scroll();
  endtask

  task automatic model_accept(logic [7:0] b);
    case (b)
      8'h0D: m_col = 0;
      8'h0A: line_feed();
      8'h08: if (m_col > 0) m_col--;
      default: begin
        push(1, 1, 11'(m_row * C + m_col), {attribute, b}, 1, 1, 0);
        if (m_col == C - 1) begin
          m_col = 0;
          line_feed();
        end else begin
          m_col++;
        end
      end
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 10000) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      chk("idle_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic send(logic [7:0] b);
    wait_idle();
    if (rnd_attr) attribute = 8'($urandom);
    repeat ($urandom_range(0, 1)) tick();
    charData  = b;
    charValid = 1'b1;
    tick();
    charValid = 1'b0;
    model_accept(b);
  endtask

  task automatic send_print();
    send(8'($urandom_range(8'h21, 8'h7E)));
  endtask

  // Clear raised together with a byte: the byte must wait out the whole clear.
  task automatic do_clear(logic [7:0] b);
    wait_idle();
    clearRequest = 1'b1;
    charValid    = 1'b1;
    charData     = b;
    push(0, 0, 11'h0, 16'h0, 1, 1, 0);
    tick();
    clearRequest = 1'b0;
    for (int i = 0; i < N; i++) push(1, 1, 11'(i), {attribute, 8'h20}, 1, 1, 0);
    m_col = 0;
    m_row = 0;
    wait_idle();
    tick();
    charValid = 1'b0;
    model_accept(b);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (rst_eff) begin
        ce.en = 0; ce.we = 0; ce.addr = 0; ce.wd = 0; ce.chk_wd = 1;
        ce.col = 0; ce.row = 0; ce.bsy = 0; ce.rdy = 0;
      end else if (q.size() > 0) begin
        ce = q.pop_front();
        if (ce.en && ce.we) scr[ce.addr] = ce.wd;
      end else begin
        ce.en = 0; ce.we = 0; ce.addr = 0; ce.wd = 0; ce.chk_wd = 1;
        ce.col = 7'(m_col); ce.row = 5'(m_row); ce.bsy = 0; ce.rdy = 1;
      end
      vectors++;
      if (ramEnable !== ce.en || ramWriteEnable !== ce.we || ramAddress !== ce.addr ||
          (ce.chk_wd && ramDataIn !== ce.wd) || cursorColumn !== ce.col ||
          cursorRow !== ce.row || busy !== ce.bsy || charReady !== ce.rdy) begin
        miscompares++;
        $display("FAIL cycle_check @%0t: got en%b we%b a%0d d%h c%0d r%0d busy%b rdy%b, want en%b we%b a%0d d%h c%0d r%0d busy%b rdy%b",
                 $time, ramEnable, ramWriteEnable, ramAddress, ramDataIn, cursorColumn, cursorRow, busy, charReady,
                 ce.en, ce.we, ce.addr, ce.wd, ce.col, ce.row, ce.bsy, ce.rdy);
      end
    end
  end

  initial begin
    int n, bad, r;
    for (int k = 0; k < 2048; k++) mem[k] = 16'h0;
    for (int k = 0; k < N; k++) scr[k] = 16'h0;
    attribute = 8'h1F;

    reset = 1'b1;
    tick();
    chk_en  = 1;
    rst_eff = 1;
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_addr", ramAddress, 0);
    tick();
    reset   = 1'b0;
    rst_eff = 0;

    send(8'h41);
    @(negedge clock);
    chk("A_addr", ramAddress, 0);
    chk("A_data", ramDataIn, 16'h1F41);
    chk("A_ready_low", charReady, 0);
    @(negedge clock);
    chk("A_col", cursorColumn, 1);
    chk("A_ready_back", charReady, 1);

    send(8'h0D);
    repeat (C) send_print();
    wait_idle();
    @(negedge clock);
    chk("wrap_col", cursorColumn, 0);
    chk("wrap_row", cursorRow, 1);

    send(8'h0A);
    send(8'h0A);
    repeat (37) send_print();
    wait_idle();
    send(8'h0D);
    @(negedge clock);
    chk("cr_col", cursorColumn, 0);
    send(8'h08);
    @(negedge clock);
    chk("bs_at_zero", cursorColumn, 0);
    repeat (10) send_print();
    send(8'h08);
    wait_idle();
    @(negedge clock);
    chk("bs_col", cursorColumn, 9);
    chk("bs_row", cursorRow, 3);

    do_clear(8'h5A);
    wait_idle();
    @(negedge clock);
    chk("clear_then_byte_col", cursorColumn, 1);
    chk("clear_then_byte_row", cursorRow, 0);

    rnd_attr = 1;
    repeat (22) send(8'h0A);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 63);
      if (r == 0) do_clear(8'($urandom_range(8'h21, 8'h7E)));
      else if (r <= 2) send(8'h0A);
      else if (r == 3) send(8'h0D);
      else if (r <= 5) send(8'h08);
      else send_print();
    end
    rnd_attr = 0;

    send(8'h0D);
    while (m_row < R - 1) send(8'h0A);
    repeat (5) send_print();
    send(8'h0A);
    n = 0;
    while (busy && n < 10000) begin
      n++;
      tick();
    end
    chk("scroll_busy_cycles", n, 3920);
    chk("scroll_col", cursorColumn, 5);
    chk("scroll_row", cursorRow, 24);

    send(8'h0A);
    repeat (999) tick();
    reset = 1'b1;
    tick();
    q.delete();
    m_col   = 0;
    m_row   = 0;
    rst_eff = 1;
    @(negedge clock);
    chk("midreset_en", ramEnable, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_row", cursorRow, 0);
    tick();
    reset   = 1'b0;
    rst_eff = 0;
    @(negedge clock);
    chk("after_reset_ready", charReady, 1);

    send(8'h42);
    wait_idle();
    tick();
    bad = 0;
    for (int k = 0; k < N; k++) if (mem[k] !== scr[k]) bad++;
    chk("ram_image", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
